// File: rtl/pool_ibuf_writer.sv
// Streams pixels into a pooling input buffer and pulses o_func_start each time a
// complete kernel_dim x kernel_dim window has been written; stalls on downstream busy.
module pool_ibuf_writer #(
    parameter int input_channels = 16,
    parameter int img_width      = 8,
    parameter int kernel_dim     = 2,
    parameter int datatype_size  = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_start,
    input  logic                                      i_data_valid,
    input  logic [datatype_size*input_channels-1:0]   i_data,
    output logic                                      o_ready,
    output logic [input_channels-1:0]                 o_ibuf_we,
    output logic [datatype_size*input_channels-1:0]   o_ibuf_wr_data,
    output logic                                      o_func_start,
    input  logic                                      i_next_busy,
    output logic                                      o_frame_done
);

    localparam int CW   = $clog2(img_width);
    localparam int LAST = img_width - 1;
    // Last column/row index that still closes a full window; trailing pixels never do.
    localparam int LIM  = img_width - img_width % kernel_dim - 1;

    typedef enum logic [2:0] {IDLE, STREAM, FUNC, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col, row;
    logic          pend_win;
    logic          last_seen;
    logic          accept;
    logic          win_px;
    logic          last_px;

    always_comb begin
        win_px  = ((int'(col) + 1) % kernel_dim == 0) && ((int'(row) + 1) % kernel_dim == 0)
               && (int'(col) <= LIM) && (int'(row) <= LIM);
        last_px = (col == CW'(LAST)) && (row == CW'(LAST));
        accept  = o_ready && i_data_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            pend_win  <= 1'b0;
            last_seen <= 1'b0;
        end else if (i_start) begin
            col       <= '0;
            row       <= '0;
            pend_win  <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            pend_win <= accept && win_px;
            if (accept) begin
                last_seen <= last_seen || last_px;
                if (col == CW'(LAST)) begin
                    col <= '0;
                    row <= (row == CW'(LAST)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ibuf_we      <= '0;
            o_ibuf_wr_data <= '0;
        end else begin
            o_ibuf_we <= {input_channels{accept}};
            if (accept) o_ibuf_wr_data <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          state <= IDLE;
        else if (i_start) state <= STREAM;
        else              state <= state_nx;
    end

    // NOTE: every path assigns state_nx (default first) so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = IDLE;
            STREAM: begin
                if (pend_win)       state_nx = FUNC;
                else if (last_seen) state_nx = DONE;
            end
            FUNC:   state_nx = WAIT;
            WAIT: begin
                if (!i_next_busy) state_nx = last_seen ? DONE : STREAM;
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready      = (state == STREAM) && !rst && !i_next_busy && !pend_win && !last_seen;
        o_func_start = (state == FUNC) && !rst;
        o_frame_done = (state == DONE) && !rst;
    end

endmodule

// File: tb/tb_pool_ibuf_writer.sv
// Randomized bench for pool_ibuf_writer: a timeline model predicts handshakes, writes,
// window pulses and frame completion for 4x4 and 5x5 images with 2x2 windows.
module tb_pool_ibuf_writer;

    localparam int CH = 2;
    localparam int DS = 2;
    localparam int KD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic       valid_s [2];
    logic       busy_s  [2];
    logic [3:0] data_s  [2];
    logic       ready_s [2];
    logic       fs_s    [2];
    logic       fd_s    [2];
    logic [1:0] we_s    [2];
    logic [3:0] wd_s    [2];

    always #5 clk = ~clk;

    pool_ibuf_writer #(.input_channels(CH), .img_width(4), .kernel_dim(KD), .datatype_size(DS)) dut4 (
        .clk(clk), .rst(rst), .i_start(start_s[0]), .i_data_valid(valid_s[0]), .i_data(data_s[0]),
        .o_ready(ready_s[0]), .o_ibuf_we(we_s[0]), .o_ibuf_wr_data(wd_s[0]),
        .o_func_start(fs_s[0]), .i_next_busy(busy_s[0]), .o_frame_done(fd_s[0]));

    pool_ibuf_writer #(.input_channels(CH), .img_width(5), .kernel_dim(KD), .datatype_size(DS)) dut5 (
        .clk(clk), .rst(rst), .i_start(start_s[1]), .i_data_valid(valid_s[1]), .i_data(data_s[1]),
        .o_ready(ready_s[1]), .o_ibuf_we(we_s[1]), .o_ibuf_wr_data(wd_s[1]),
        .o_func_start(fs_s[1]), .i_next_busy(busy_s[1]), .o_frame_done(fd_s[1]));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model timeline: absolute cycle numbers at which each event is due.
    int         p, fs_at, fd_at, we_at, wait_start;
    bit         active, blocked, done_after_wait, just_rst;
    logic [3:0] wd_val;

    // busy_mode: 0 never busy, 1 random busy, 2 busy for 5 cycles right after the first window pulse.
    task automatic run_frame(input int k, input int w, input int valid_pct, input int busy_mode,
                             input int abort_at, input int rst_at, input int exp_fs);
        int fs_seen = 0;
        int we_seen = 0;
        int fd_seen = 0;
        int first_fs = -1;
        int c = 0;
        bit aborted = 0;
        bit did_rst = 0;
        bit start_next = 1;
        bit fin = 0;
        int lim = w - w % KD - 1;
        p = 0; fs_at = -1; fd_at = -1; we_at = -1;
        active = 0; blocked = 0; done_after_wait = 0; just_rst = 0;
        while (!fin && c < 3000) begin
            bit st, vl, bs, rs, rdy_exp, acc, win, last;
            int idx, col, row;
            logic [3:0] dt;
            @(posedge clk);
            #1;
            st = start_next;
            start_next = 0;
            rs = 0;
            if (!did_rst && rst_at >= 0 && active && p == rst_at) begin
                rs = 1; did_rst = 1; start_next = 1;
            end else if (!aborted && abort_at >= 0 && active && p == abort_at) begin
                st = 1; aborted = 1;
            end
            vl = !st && ($urandom_range(99) < valid_pct);
            case (busy_mode)
                1:       bs = ($urandom_range(99) < 30);
                2:       bs = (first_fs >= 0) && (c > first_fs) && (c <= first_fs + 5);
                default: bs = 0;
            endcase
            dt = 4'($urandom);
            start_s[k] = st; valid_s[k] = vl; busy_s[k] = bs; data_s[k] = dt; rst = rs;
            @(negedge clk);

            rdy_exp = !rs && active && !blocked && !bs && (p < w * w);
            check($sformatf("ready w%0d c%0d", w, c), ready_s[k], rdy_exp);
            check($sformatf("ibuf_we w%0d c%0d", w, c), we_s[k], (we_at == c) ? 2'b11 : 2'b00);
            if (we_at == c) check($sformatf("wr_data w%0d c%0d", w, c), wd_s[k], wd_val);
            if (just_rst)   check("wr_data_after_rst", wd_s[k], 0);
            check($sformatf("func_start w%0d c%0d", w, c), fs_s[k], (fs_at == c) && !rs);
            check($sformatf("frame_done w%0d c%0d", w, c), fd_s[k], (fd_at == c) && !rs);
            if (we_s[k] != 0) we_seen++;
            if (fs_s[k])      fs_seen++;
            if (fd_s[k])      fd_seen++;
            just_rst = rs;

            acc = rdy_exp && vl;
            if (rs) begin
                active = 0; blocked = 0; p = 0;
                fs_at = -1; fd_at = -1; we_at = -1;
                fs_seen = 0; we_seen = 0; fd_seen = 0;
            end else begin
                if (acc) begin
                    we_at = c + 1;
                    wd_val = dt;
                end
                if (st) begin
                    active = 1; blocked = 0; p = 0;
                    fs_at = -1; fd_at = -1;
                    fs_seen = 0; we_seen = 0; fd_seen = 0;
                end else if (acc) begin
                    idx = p;
                    p++;
                    col = idx % w;
                    row = idx / w;
                    win = ((col + 1) % KD == 0) && ((row + 1) % KD == 0) && col <= lim && row <= lim;
                    last = (p == w * w);
                    if (win) begin
                        fs_at = c + 2;
                        blocked = 1;
                        wait_start = c + 3;
                        done_after_wait = last;
                        if (first_fs < 0) first_fs = c + 2;
                    end else if (last) begin
                        fd_at = c + 2;
                    end
                end
                if (blocked && !st && c >= wait_start && !bs) begin
                    blocked = 0;
                    if (done_after_wait) fd_at = c + 1;
                end
            end
            if (fd_at >= 0 && c >= fd_at + 2) fin = 1;
            c++;
        end
        if (!fin) check("timeout", 0, 1);
        check($sformatf("write_count w%0d", w), we_seen, w * w);
        check($sformatf("func_pulses w%0d", w), fs_seen, exp_fs);
        check($sformatf("frame_done_count w%0d", w), fd_seen, 1);
        start_s[k] = 0; valid_s[k] = 0; busy_s[k] = 0; data_s[k] = '0;
    endtask

    initial begin
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 0; valid_s[k] = 0; busy_s[k] = 0; data_s[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", ready_s[k], 0);
            check("rst_we", we_s[k], 0);
            check("rst_wr_data", wd_s[k], 0);
            check("rst_func_start", fs_s[k], 0);
            check("rst_frame_done", fd_s[k], 0);
        end
        @(posedge clk);
        #1 rst = 0;

        run_frame(0, 4, 100, 0, -1, -1, 4);
        run_frame(0, 4, 100, 2, -1, -1, 4);
        for (int i = 0; i < 3; i++) run_frame(0, 4, 60, 1, -1, -1, 4);
        run_frame(1, 5, 100, 0, -1, -1, 4);
        run_frame(1, 5, 70, 1, -1, -1, 4);
        run_frame(0, 4, 100, 0, 10, -1, 4);
        run_frame(0, 4, 80, 1, -1, 8, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
